// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: FSM state encoding and a counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, clamped to 1 so a single-digit configuration still has a counter bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its top bit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] c;

    assign c[0] = c_i;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign s_o[gi]  = a_i[gi] ^ b_i[gi] ^ c[gi];
            assign c[gi+1]  = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign c_o     = c[DIGIT];
    assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, with
// carry/borrow and signed-overflow flags and valid/ready handshakes.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cy_q;
    logic                carry_q;
    logic                ovf_q;
    logic [CW-1:0]       cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [DIGIT-1:0]       d_sum;
    logic                   d_cout;
    logic                   d_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_d;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (cy_q),
        .s_o     (d_sum),
        .c_o     (d_cout),
        .c_msb_o (d_cmsb)
    );

    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    assign sum_cat = {d_sum, sum_q} >> DIGIT;
    assign sum_d   = sum_cat[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cy_q        <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        cy_q       <= sub;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    sum_q <= sum_d;
                    cy_q  <= d_cout;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        carry_q     <= d_cout;
                        ovf_q       <= d_cout ^ d_cmsb;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8.
module tb_serial_addsub;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        overflow;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        sub8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        carry8;
    logic        overflow8;
    logic        busy8;

    int n_tests;
    int n_fail;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry(carry8), .overflow(overflow8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        start_op(av, bv, sv);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_carry"}, 32'(carry), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        handoff();
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb, rs;
        logic        rsub, rc, ro;
        logic [16:0] wide;

        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; out_ready8 = 0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", {30'd0, carry, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub1", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op("sub_ovf", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // Back-pressure: result must hold while inputs churn.
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); sub = i[0]; in_valid = ~i[0];
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'h5555);
            check("bp_flags", {30'd0, carry, overflow}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handoff();

        // Reset abort two cycles into RUN.
        start_op(16'h00FF, 16'h0F0F, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_flags", {30'd0, carry, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_stale", 32'(out_valid), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // N=1 instance.
        @(negedge clk);
        check("n1_in_ready", 32'(in_ready8), 32'd1);
        a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("n1_busy", 32'(busy8), 32'd1);
        @(posedge clk); #1;
        check("n1_out_valid", 32'(out_valid8), 32'd1);
        check("n1_sum", 32'(sum8), 32'h00);
        check("n1_carry", 32'(carry8), 32'd1);
        check("n1_ovf", 32'(overflow8), 32'd1);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("n1_handoff", {30'd0, out_valid8, in_ready8}, 32'd1);

        // Random pairs against reference arithmetic.
        for (int i = 0; i < 256; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rsub = 1'($urandom);
            if (rsub) begin
                rs = ra - rb;
                rc = (ra >= rb);
                ro = (ra[15] != rb[15]) && (rs[15] != ra[15]);
            end else begin
                wide = {1'b0, ra} + {1'b0, rb};
                rs = wide[15:0];
                rc = wide[16];
                ro = (ra[15] == rb[15]) && (rs[15] != ra[15]);
            end
            do_op("rand", ra, rb, rsub, rs, rc, ro);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
